// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin select sequencer for the 4:1 x 4-bit channel mux.
// Walks the channels enabled in ch_mask. Each channel is held for DWELL cycles
// before the scanner moves on. The block drives the mux selects {s1,s0} and
// emits ch_done / scan_wrap strobes.
// Optional build macro SCAN_CAPTURE_EN adds a capture port. On every completed
// dwell it latches the mux output together with the channel it came from.
module mux_sel_scanner #(
  parameter int DWELL   = 8,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic [3:0] ch_mask,
`ifdef SCAN_CAPTURE_EN
  input  logic [3:0] mux_e,
  output logic [3:0] cap_data,
  output logic [1:0] cap_ch,
  output logic       cap_valid,
`endif
  output logic       s0,
  output logic       s1,
  output logic       sel_valid,
  output logic       ch_done,
  output logic       scan_wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  state_t             state;
  logic [1:0]         cur_ch;
  logic [DWELL_W-1:0] cnt;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       wraps;
  logic       any_on;
  logic       cur_on;
  logic       go_idle;
  logic       do_abort;
  logic       do_adv;

  // Lowest enabled channel: the starting point of a fresh scan.
  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    logic [1:0] res;
    logic       found;
    res   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && mask[k]) begin
        res   = 2'(k);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // First enabled channel after cur, searched cyclically.
  // The search falls back to cur itself when cur is the only channel enabled.
  function automatic logic [1:0] cyclic_next(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign any_on   = |ch_mask;
  assign cur_on   = ch_mask[cur_ch];
  assign first_ch = lowest_ch(ch_mask);
  assign next_ch  = cyclic_next(cur_ch, ch_mask);
  assign wraps    = (next_ch <= cur_ch);

  // Decisions taken in RUN, in priority order: stop, abort, hold, advance, count.
  assign go_idle  = (state == RUN) && (!en || !any_on);
  assign do_abort = (state == RUN) && !go_idle && !cur_on;
  assign do_adv   = (state == RUN) && !go_idle && cur_on && !hold && (cnt == LAST);

  // Scan FSM: channel pointer, dwell counter and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ch    <= 2'd0;
      cnt       <= '0;
      sel_valid <= 1'b0;
      ch_done   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      ch_done   <= 1'b0;
      scan_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (en && any_on) begin
            state     <= RUN;
            cur_ch    <= first_ch;
            cnt       <= '0;
            sel_valid <= 1'b1;
          end
        end
        RUN: begin
          if (go_idle) begin
            // The selects keep pointing at the last channel while idle.
            state     <= IDLE;
            sel_valid <= 1'b0;
            cnt       <= '0;
          end else if (do_abort) begin
            cur_ch    <= next_ch;
            cnt       <= '0;
            scan_wrap <= wraps;
          end else if (hold) begin
            cnt <= cnt;
          end else if (do_adv) begin
            cur_ch    <= next_ch;
            cnt       <= '0;
            ch_done   <= 1'b1;
            scan_wrap <= wraps;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0 = cur_ch[0];
  assign s1 = cur_ch[1];

`ifdef SCAN_CAPTURE_EN
  // Capture the settled mux output of the outgoing channel on each completed dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data  <= 4'd0;
      cap_ch    <= 2'd0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= do_adv;
      if (do_adv) begin
        cap_data <= mux_e;
        cap_ch   <= cur_ch;
      end
    end
  end
`endif

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream sequencer for the 4:1 x 4-bit channel mux. Drives the mux select pair (s0, s1).
- Steps round-robin through the enabled channels and holds each one for a programmable dwell time.
- Emits per-channel and per-scan strobes so downstream logic knows when the mux output is settled and which channel it belongs to.

Parameters:
- DWELL, 8, clock cycles each channel stays selected; legal range 1..2^DWELL_W-1.
- DWELL_W, 8, width of the internal dwell counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable.
- hold  input  1  freezes the dwell counter and the current channel.
- ch_mask  input  4  bit i=1 means channel i takes part in the scan.
- s0  output  1  mux select LSB (= cur_ch[0]; picks within the pair).
- s1  output  1  mux select MSB (= cur_ch[1]; picks between pairs).
- sel_valid  output  1  selects are driven by an active scan.
- ch_done  output  1  one-cycle pulse: a channel just completed its full dwell.
- scan_wrap  output  1  one-cycle pulse: the advance wrapped to an equal or lower channel index.

Behaviour:
- Reset (asynchronous, active-low):
  - s0=0, s1=0, sel_valid=0, ch_done=0, scan_wrap=0.
  - cur_ch=0, cnt=0, state=IDLE.
- All outputs are registered. Decisions use inputs sampled at the rising edge.
- IDLE state:
  - Enter RUN when en=1 and ch_mask!=0.
  - On entry: cur_ch = lowest set bit of ch_mask, cnt=0, sel_valid=1 from the next cycle.
- RUN state, in priority order:
  1. en=0 or ch_mask==0 → IDLE. sel_valid=0, cnt=0, s0/s1 keep their last value, no strobes.
  2. ch_mask[cur_ch]==0 (current channel disabled mid-dwell) → abort the dwell. Jump to the next enabled channel, cnt=0, no ch_done, scan_wrap computed as for a normal advance.
  3. hold=1 → nothing changes. Strobes stay 0.
  4. cnt==DWELL-1 → advance. cur_ch=next, cnt=0, ch_done=1 for one cycle. In that cycle s0/s1 already show the new channel.
  5. Otherwise cnt=cnt+1.
- Next channel: first set bit of ch_mask searched cyclically from cur_ch+1 (mod 4).
  - If cur_ch is the only set bit, the scan stays on it; ch_done and scan_wrap still pulse each dwell.
  - scan_wrap=1 when next<=cur_ch.
- DWELL=1: the channel advances every cycle and ch_done is high continuously while in RUN.
- Mask changes take effect at the next advance, except the abort and all-zero cases above.
- Reset asserted mid-scan returns all outputs to their reset values immediately.

Optional Feature:
- Macro: SCAN_CAPTURE_EN.
- With the macro defined:
  - Adds input mux_e[3:0] (the mux output), output cap_data[3:0], output cap_ch[1:0] and output cap_valid.
  - On every normal advance (rule 4): cap_data<=mux_e, cap_ch<=outgoing cur_ch, cap_valid=1 for one cycle, aligned with ch_done.
  - No capture on an abort, on hold, or in IDLE.
  - Reset value of all capture outputs is 0.
- Without the macro: the capture ports and their logic are absent.

Test Plan:
- DWELL=4, mask=4'b1111, en=1 held → each of {s1,s0}=00,01,10,11 lasts 4 cycles. ch_done pulses every 4th cycle. scan_wrap pulses only on the 11→00 advance. sel_valid=1 one cycle after en.
- mask=4'b1010, DWELL=2 → selects alternate 01,11. scan_wrap on each 11→01 advance.
- hold=1 for 5 cycles mid-dwell on channel 2 → selects stay 10, no strobes. Remaining dwell completes after hold drops (total high-select time = DWELL+5).
- mask bit of the current channel 1 cleared at dwell cycle 1 → next edge moves to the next set channel, ch_done stays 0. Mask=0 → sel_valid=0 next cycle, selects frozen.
- rst_n pulsed low mid-dwell on channel 3 → s0=s1=0 and sel_valid=0 immediately. Scan restarts at the lowest set channel after release.
- SCAN_CAPTURE_EN defined, mux_e driven as 4'hA on ch0, 4'h5 on ch1 → cap_data=A with cap_ch=0, then cap_data=5 with cap_ch=1. cap_valid coincides with ch_done each time.
